memorio_bridge: RTL and testbench

Parametrised successor of the CPU-side memory/IO glue, sitting between execute/control and the data memory plus N_IO peripheral channels.
- Memory accesses stay zero-wait pass-through.
- IO accesses are decoded to one of N_IO channels and run a registered request/ready handshake, stalling the CPU until the peripheral answers or a timeout fires.
- Drives zeros instead of tri-state when idle, and reports bus errors.

---
 rtl/memorio_pkg.sv | 23 ++
 rtl/memorio_bridge_if.sv | 37 +++
 rtl/io_addr_decode.sv | 25 ++
 rtl/memorio_bridge.sv | 146 ++++++++++++++
 tb/tb_memorio_bridge.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/memorio_pkg.sv
// Shared types and helpers for the CPU memory/IO bridge.
package memorio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] IO_BASE_DEFAULT  = 32'hFFFF_FC00;
  localparam int          CH_SHIFT_DEFAULT = 4;
  localparam int          ZEXT_MAX_W       = 64;

  // Keeps the low io_w bits of val and clears the rest.
  function automatic logic [ZEXT_MAX_W-1:0] zext_io(input logic [ZEXT_MAX_W-1:0] val,
                                                    input int io_w);
    logic [ZEXT_MAX_W-1:0] mask;
    mask = (io_w >= ZEXT_MAX_W) ? '1
                                : ((ZEXT_MAX_W'(1) << io_w) - ZEXT_MAX_W'(1));
    return val & mask;
  endfunction

endpackage

// File: rtl/memorio_bridge_if.sv
// CPU-side and peripheral-side signals of the memory/IO bridge.
interface memorio_bridge_if #(
  parameter int DATA_W = 32,
  parameter int IO_W   = 16,
  parameter int N_IO   = 4
);
  logic                   memread;
  logic                   memwrite;
  logic                   ioread;
  logic                   iowrite;
  logic [DATA_W-1:0]      caddress;
  logic [DATA_W-1:0]      rdata;
  logic [DATA_W-1:0]      mread_data;
  logic [N_IO*IO_W-1:0]   io_rdata;
  logic [N_IO-1:0]        io_ready;
  logic [DATA_W-1:0]      address;
  logic [DATA_W-1:0]      write_data;
  logic [DATA_W-1:0]      wdata;
  logic [N_IO-1:0]        io_cs;
  logic                   io_rd;
  logic                   io_wr;
  logic [IO_W-1:0]        io_wdata;
  logic                   stall;
  logic                   bus_err;

  modport slave (
    input  memread, memwrite, ioread, iowrite, caddress, rdata, mread_data,
           io_rdata, io_ready,
    output address, write_data, wdata, io_cs, io_rd, io_wr, io_wdata, stall, bus_err
  );

  modport master (
    output memread, memwrite, ioread, iowrite, caddress, rdata, mread_data,
           io_rdata, io_ready,
    input  address, write_data, wdata, io_cs, io_rd, io_wr, io_wdata, stall, bus_err
  );
endinterface

// File: rtl/io_addr_decode.sv
// Maps a CPU address onto an IO channel index and flags addresses outside the IO window.
module io_addr_decode
  import memorio_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                N_IO     = 4,
  parameter logic [DATA_W-1:0] IO_BASE  = DATA_W'(IO_BASE_DEFAULT),
  parameter int                CH_SHIFT = CH_SHIFT_DEFAULT,
  parameter int                CH_W     = 2
) (
  input  logic [DATA_W-1:0] caddress,
  output logic [CH_W-1:0]   ch,
  output logic              in_range
);

  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] idx;

  assign offset   = caddress - IO_BASE;
  assign idx      = offset >> CH_SHIFT;
  // Below-base addresses wrap to huge offsets, so the base compare is still needed.
  assign in_range = (caddress >= IO_BASE) && (idx < DATA_W'(N_IO));
  assign ch       = idx[CH_W-1:0];

endmodule

// File: rtl/memorio_bridge.sv
// Memory pass-through plus N_IO-channel IO handshake with timeout and bus-error reporting.
module memorio_bridge
  import memorio_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                IO_W     = 16,
  parameter int                N_IO     = 4,
  parameter logic [DATA_W-1:0] IO_BASE  = DATA_W'(IO_BASE_DEFAULT),
  parameter int                CH_SHIFT = CH_SHIFT_DEFAULT,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  memorio_bridge_if.slave   bus
);

  localparam int CH_W  = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic              dir_rd_reg, dir_rd_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] rd_buf_reg, rd_buf_next;
  logic [IO_W-1:0]   io_wdata_reg, io_wdata_next;

  logic [CH_W-1:0]   dec_ch;
  logic              dec_in_range;
  logic              io_sel;
  logic              io_req;
  logic              ready_sel;
  logic [IO_W-1:0]   rdata_sel;
  logic              timeout_hit;
  logic              stall_c;
  logic              bus_err_c;
  logic [N_IO-1:0]   io_cs_vec;

  io_addr_decode #(
    .DATA_W   (DATA_W),
    .N_IO     (N_IO),
    .IO_BASE  (IO_BASE),
    .CH_SHIFT (CH_SHIFT),
    .CH_W     (CH_W)
  ) u_decode (
    .caddress (bus.caddress),
    .ch       (dec_ch),
    .in_range (dec_in_range)
  );

  assign io_sel      = bus.ioread | bus.iowrite;
  // Reset masks the request so stall/bus_err drop immediately while reset_n is low.
  assign io_req      = io_sel & reset_n;
  assign ready_sel   = bus.io_ready[ch_reg];
  assign rdata_sel   = bus.io_rdata[ch_reg*IO_W +: IO_W];
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ch_reg       <= '0;
      dir_rd_reg   <= 1'b0;
      cnt_reg      <= '0;
      rd_buf_reg   <= '0;
      io_wdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      dir_rd_reg   <= dir_rd_next;
      cnt_reg      <= cnt_next;
      rd_buf_reg   <= rd_buf_next;
      io_wdata_reg <= io_wdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    dir_rd_next   = dir_rd_reg;
    cnt_next      = cnt_reg;
    rd_buf_next   = rd_buf_reg;
    io_wdata_next = io_wdata_reg;
    stall_c       = 1'b0;
    bus_err_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (io_req) begin
          stall_c     = 1'b1;
          dir_rd_next = bus.ioread;
          cnt_next    = '0;
          if (dec_in_range) begin
            ch_next       = dec_ch;
            io_wdata_next = bus.rdata[IO_W-1:0];
            state_next    = ACCESS;
          end else begin
            bus_err_c   = 1'b1;
            rd_buf_next = '0;
            state_next  = DONE;
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        // Ready is checked first so a coincident timeout is not reported.
        if (ready_sel) begin
          if (dir_rd_reg) begin
            rd_buf_next = DATA_W'(zext_io(ZEXT_MAX_W'(rdata_sel), IO_W));
          end
          state_next = DONE;
        end else if (timeout_hit) begin
          bus_err_c   = 1'b1;
          rd_buf_next = '0;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_IO; gi++) begin : g_cs
    assign io_cs_vec[gi] = (state_reg == ACCESS) && (ch_reg == CH_W'(gi));
  end

  always_comb begin
    bus.wdata = '0;
    if (state_reg == DONE) begin
      bus.wdata = dir_rd_reg ? rd_buf_reg : '0;
    end else if (!io_sel && bus.memread) begin
      bus.wdata = bus.mread_data;
    end
  end

  assign bus.address    = bus.caddress;
  assign bus.write_data = (bus.memwrite && !io_sel) ? bus.rdata : '0;
  assign bus.io_cs      = io_cs_vec;
  assign bus.io_rd      = (state_reg == ACCESS) && dir_rd_reg;
  assign bus.io_wr      = (state_reg == ACCESS) && !dir_rd_reg;
  assign bus.io_wdata   = io_wdata_reg;
  assign bus.stall      = stall_c;
  assign bus.bus_err    = bus_err_c;

endmodule

// File: tb/tb_memorio_bridge.sv
// Directed bench for memorio_bridge: memory pass-through, IO read/write, timeout, range errors, reset.
module tb_memorio_bridge;

  localparam int DATA_W = 32;
  localparam int IO_W   = 16;
  localparam int N_IO   = 4;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  memorio_bridge_if #(.DATA_W(DATA_W), .IO_W(IO_W), .N_IO(N_IO)) bus ();

  memorio_bridge #(
    .DATA_W   (DATA_W),
    .IO_W     (IO_W),
    .N_IO     (N_IO),
    .IO_BASE  (32'hFFFF_FC00),
    .CH_SHIFT (4),
    .TIMEOUT  (15)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input bit ok);
    n_checks = n_checks + 1;
    if (ok) n_pass = n_pass + 1;
    else $error("FAIL %s", tag);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.ioread     = 1'b0;
    bus.iowrite    = 1'b0;
    bus.caddress   = '0;
    bus.rdata      = '0;
    bus.mread_data = '0;
    bus.io_rdata   = 64'h1111_BEEF_3333_4444;
    bus.io_ready   = '0;

    #2;
    check("rst_stall", bus.stall === 1'b0);
    check("rst_io_cs", bus.io_cs === 4'b0000);
    check("rst_bus_err", bus.bus_err === 1'b0);
    check("rst_io_wdata", bus.io_wdata === 16'h0000);
    mid();
    mid();
    reset_n = 1'b1;

    next_cycle();
    bus.memread = 1'b1; bus.mread_data = 32'h1234_5678; bus.caddress = 32'h0000_0100;
    mid();
    check("mem_wdata", bus.wdata === 32'h1234_5678);
    check("mem_stall", bus.stall === 1'b0);
    check("mem_io_cs", bus.io_cs === 4'b0000);
    check("mem_address", bus.address === 32'h0000_0100);
    next_cycle();
    bus.memread = 1'b0; bus.memwrite = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    mid();
    check("mem_write_data", bus.write_data === 32'hDEAD_BEEF);
    check("mem_wdata_idle", bus.wdata === 32'h0);
    $display("txn mem load/store done");
    next_cycle();
    bus.memwrite = 1'b0;

    bus.ioread = 1'b1; bus.caddress = 32'hFFFF_FC20;
    mid();
    check("rd2_c0_stall", bus.stall === 1'b1);
    check("rd2_c0_io_cs", bus.io_cs === 4'b0000);
    next_cycle(); mid();
    check("rd2_c1_io_cs", bus.io_cs === 4'b0100);
    check("rd2_c1_io_rd", bus.io_rd === 1'b1);
    check("rd2_c1_stall", bus.stall === 1'b1);
    next_cycle(); mid();
    check("rd2_c2_io_cs", bus.io_cs === 4'b0100);
    check("rd2_c2_stall", bus.stall === 1'b1);
    next_cycle();
    bus.io_ready = 4'b0100;
    mid();
    check("rd2_c3_io_cs", bus.io_cs === 4'b0100);
    check("rd2_c3_stall", bus.stall === 1'b1);
    next_cycle();
    bus.io_ready = 4'b0000;
    mid();
    check("rd2_done_stall", bus.stall === 1'b0);
    check("rd2_done_wdata", bus.wdata === 32'h0000_BEEF);
    check("rd2_done_io_cs", bus.io_cs === 4'b0000);
    check("rd2_done_io_rd", bus.io_rd === 1'b0);
    next_cycle();
    bus.ioread = 1'b0;
    mid();
    check("rd2_idle_stall", bus.stall === 1'b0);
    $display("txn io read ch2 done");

    next_cycle();
    bus.iowrite = 1'b1; bus.memwrite = 1'b1; bus.caddress = 32'hFFFF_FC00;
    bus.rdata = 32'hCAFE_A5A5;
    mid();
    check("wr0_c0_stall", bus.stall === 1'b1);
    check("wr0_write_data", bus.write_data === 32'h0);
    next_cycle(); mid();
    check("wr0_io_wdata", bus.io_wdata === 16'hA5A5);
    check("wr0_io_wr", bus.io_wr === 1'b1);
    check("wr0_io_rd", bus.io_rd === 1'b0);
    check("wr0_io_cs", bus.io_cs === 4'b0001);
    next_cycle();
    bus.io_ready = 4'b0001;
    mid();
    check("wr0_c2_io_cs", bus.io_cs === 4'b0001);
    next_cycle();
    bus.io_ready = 4'b0000;
    mid();
    check("wr0_done_stall", bus.stall === 1'b0);
    check("wr0_done_io_wr", bus.io_wr === 1'b0);
    check("wr0_done_bus_err", bus.bus_err === 1'b0);
    next_cycle();
    bus.iowrite = 1'b0; bus.memwrite = 1'b0;
    $display("txn io write ch0 done");

    bus.ioread = 1'b1; bus.caddress = 32'hFFFF_FC10;
    mid();
    check("to_c0_stall", bus.stall === 1'b1);
    for (int k = 1; k <= 15; k++) begin
      next_cycle(); mid();
      check($sformatf("to_c%0d_bus_err", k), bus.bus_err === ((k == 15) ? 1'b1 : 1'b0));
      check($sformatf("to_c%0d_stall", k), bus.stall === 1'b1);
      check($sformatf("to_c%0d_io_cs", k), bus.io_cs === 4'b0010);
    end
    next_cycle(); mid();
    check("to_done_bus_err", bus.bus_err === 1'b0);
    check("to_done_stall", bus.stall === 1'b0);
    check("to_done_wdata", bus.wdata === 32'h0);
    next_cycle();
    bus.ioread = 1'b0;
    mid();
    check("to_idle_stall", bus.stall === 1'b0);
    check("to_idle_io_cs", bus.io_cs === 4'b0000);
    $display("txn io timeout ch1 done");

    next_cycle();
    bus.ioread = 1'b1; bus.caddress = 32'hFFFF_FC40;
    mid();
    check("oor_bus_err", bus.bus_err === 1'b1);
    check("oor_stall", bus.stall === 1'b1);
    check("oor_io_cs", bus.io_cs === 4'b0000);
    next_cycle(); mid();
    check("oor_done_stall", bus.stall === 1'b0);
    check("oor_done_bus_err", bus.bus_err === 1'b0);
    check("oor_done_wdata", bus.wdata === 32'h0);
    next_cycle();
    bus.ioread = 1'b0;
    mid();
    check("oor_idle_stall", bus.stall === 1'b0);
    $display("txn io out-of-range done");

    next_cycle();
    bus.iowrite = 1'b1; bus.caddress = 32'h0000_1000;
    mid();
    check("low_bus_err", bus.bus_err === 1'b1);
    next_cycle(); mid();
    check("low_done_stall", bus.stall === 1'b0);
    next_cycle();
    bus.iowrite = 1'b0;
    $display("txn io below-base done");

    bus.ioread = 1'b1; bus.caddress = 32'hFFFF_FC30;
    next_cycle();
    check("rstm_io_cs_before", bus.io_cs === 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstm_io_cs", bus.io_cs === 4'b0000);
    check("rstm_stall", bus.stall === 1'b0);
    check("rstm_io_rd", bus.io_rd === 1'b0);
    bus.ioread = 1'b0;
    mid();
    reset_n = 1'b1;
    next_cycle(); mid();
    check("rstm_after_bus_err", bus.bus_err === 1'b0);
    check("rstm_after_stall", bus.stall === 1'b0);
    check("rstm_after_io_cs", bus.io_cs === 4'b0000);
    $display("txn reset mid-access done");

    next_cycle();
    bus.ioread = 1'b1; bus.caddress = 32'hFFFF_FC30; bus.io_ready = 4'b1000;
    mid();
    check("min_c0_stall", bus.stall === 1'b1);
    next_cycle(); mid();
    check("min_c1_stall", bus.stall === 1'b1);
    check("min_c1_io_cs", bus.io_cs === 4'b1000);
    next_cycle(); mid();
    check("min_done_stall", bus.stall === 1'b0);
    check("min_done_wdata", bus.wdata === 32'h0000_1111);
    next_cycle();
    bus.ioread = 1'b0; bus.io_ready = 4'b0000;
    $display("txn io read ch3 min-latency done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
